// File: rtl/ex_issue_stage_if.sv
// Bus bundle for ex_issue_stage: decode-side capture, forwarding sources and the ALU-side register.
// Handshake: a transfer happens on a rising clk edge where valid && ready; valid holds steady and payload stays stable until then.
interface ex_issue_stage_if #(
    parameter int WIDTH   = 32,
    parameter int REGADDR = 5
);
    logic               in_valid;
    logic               in_ready;
    logic [6:0]         in_opcode;
    logic [2:0]         in_funct3;
    logic [6:0]         in_funct7;
    logic [REGADDR-1:0] in_rs1;
    logic [REGADDR-1:0] in_rs2;
    logic [REGADDR-1:0] in_rd;
    logic [WIDTH-1:0]   in_rs1_data;
    logic [WIDTH-1:0]   in_rs2_data;
    logic [WIDTH-1:0]   in_imm;
    logic               exmem_wen;
    logic               exmem_is_load;
    logic [REGADDR-1:0] exmem_rd;
    logic [WIDTH-1:0]   exmem_result;
    logic               wb_wen;
    logic [REGADDR-1:0] wb_rd;
    logic [WIDTH-1:0]   wb_data;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   op1;
    logic [WIDTH-1:0]   op2;
    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic [REGADDR-1:0] rd;

    modport master (
        output in_valid, in_opcode, in_funct3, in_funct7, in_rs1, in_rs2, in_rd,
               in_rs1_data, in_rs2_data, in_imm,
               exmem_wen, exmem_is_load, exmem_rd, exmem_result,
               wb_wen, wb_rd, wb_data, flush, out_ready,
        input  in_ready, out_valid, op1, op2, opcode, funct3, funct7, rd
    );

    modport slave (
        input  in_valid, in_opcode, in_funct3, in_funct7, in_rs1, in_rs2, in_rd,
               in_rs1_data, in_rs2_data, in_imm,
               exmem_wen, exmem_is_load, exmem_rd, exmem_result,
               wb_wen, wb_rd, wb_data, flush, out_ready,
        output in_ready, out_valid, op1, op2, opcode, funct3, funct7, rd
    );
endinterface

// File: rtl/ex_issue_stage.sv
// Decode-to-execute register: operand forwarding, OP-IMM immediate select, load-use stall, flush.
// Build option EX_FORWARD_EN enables forwarding/held-entry snooping; without it every pending write stalls.
module ex_issue_stage #(
    parameter int WIDTH   = 32,
    parameter int REGADDR = 5
) (
    input logic            clk,
    input logic            rst,
    ex_issue_stage_if.slave bus
);
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;

    logic               out_valid_q;
    logic [WIDTH-1:0]   op1_q, op2_q;
    logic [6:0]         opcode_q, funct7_q;
    logic [2:0]         funct3_q;
    logic [REGADDR-1:0] rd_q;

    logic use_rs1, use_rs2;
    logic hit_ex1, hit_ex2, hit_wb1, hit_wb2;
    logic hazard, ready, capture;
    logic [WIDTH-1:0] src1, src2, op2_sel;
    logic [6:0]       funct7_sel;

    always_comb begin
        use_rs1 = (bus.in_opcode == OPC_OP) || (bus.in_opcode == OPC_OPIMM) ||
                  (bus.in_opcode == OPC_LOAD);
        use_rs2 = (bus.in_opcode == OPC_OP);
        hit_ex1 = use_rs1 && bus.exmem_wen && (bus.exmem_rd != '0) && (bus.exmem_rd == bus.in_rs1);
        hit_ex2 = use_rs2 && bus.exmem_wen && (bus.exmem_rd != '0) && (bus.exmem_rd == bus.in_rs2);
        hit_wb1 = use_rs1 && bus.wb_wen && (bus.wb_rd != '0) && (bus.wb_rd == bus.in_rs1);
        hit_wb2 = use_rs2 && bus.wb_wen && (bus.wb_rd != '0) && (bus.wb_rd == bus.in_rs2);
    end

`ifdef EX_FORWARD_EN
    // Only a load in EX/MEM cannot be forwarded yet; everything else resolves by bypass.
    assign hazard = bus.exmem_is_load && (hit_ex1 || hit_ex2);

    always_comb begin
        src1 = bus.in_rs1_data;
        src2 = bus.in_rs2_data;
        if (hit_wb1) src1 = bus.wb_data;
        if (hit_ex1 && !bus.exmem_is_load) src1 = bus.exmem_result;
        if (hit_wb2) src2 = bus.wb_data;
        if (hit_ex2 && !bus.exmem_is_load) src2 = bus.exmem_result;
        if (bus.in_rs1 == '0) src1 = '0;
        if (bus.in_rs2 == '0) src2 = '0;
    end
`else
    // No bypass network: any in-flight write to a used source must retire first.
    assign hazard = hit_ex1 || hit_ex2 || hit_wb1 || hit_wb2;

    always_comb begin
        src1 = bus.in_rs1_data;
        src2 = bus.in_rs2_data;
        if (bus.in_rs1 == '0) src1 = '0;
        if (bus.in_rs2 == '0) src2 = '0;
    end

    logic unused_nofwd;
    assign unused_nofwd = ^{bus.exmem_is_load, bus.exmem_result, bus.wb_data};
`endif

    always_comb begin
        op2_sel    = bus.in_imm;
        funct7_sel = 7'd0;
        if (bus.in_opcode == OPC_OP) begin
            op2_sel    = src2;
            funct7_sel = bus.in_funct7;
        end else if ((bus.in_opcode == OPC_OPIMM) && (bus.in_funct3 == 3'b101)) begin
            funct7_sel = bus.in_imm[11:5];
        end
    end

    assign ready   = (!out_valid_q || bus.out_ready) && !hazard && !bus.flush;
    assign capture = bus.in_valid && ready;

`ifdef EX_FORWARD_EN
    logic [REGADDR-1:0] held_rs1, held_rs2;
    logic               held_use1, held_use2;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            op1_q       <= '0;
            op2_q       <= '0;
            opcode_q    <= '0;
            funct3_q    <= '0;
            funct7_q    <= '0;
            rd_q        <= '0;
`ifdef EX_FORWARD_EN
            held_rs1    <= '0;
            held_rs2    <= '0;
            held_use1   <= 1'b0;
            held_use2   <= 1'b0;
`endif
        end else if (bus.flush) begin
            out_valid_q <= 1'b0;
        end else if (capture) begin
            out_valid_q <= 1'b1;
            op1_q       <= src1;
            op2_q       <= op2_sel;
            opcode_q    <= bus.in_opcode;
            funct3_q    <= bus.in_funct3;
            funct7_q    <= funct7_sel;
            rd_q        <= bus.in_rd;
`ifdef EX_FORWARD_EN
            held_rs1    <= bus.in_rs1;
            held_rs2    <= bus.in_rs2;
            held_use1   <= use_rs1;
            held_use2   <= use_rs2;
`endif
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
`ifdef EX_FORWARD_EN
        end else if (out_valid_q && bus.wb_wen && (bus.wb_rd != '0)) begin
            // A stalled entry keeps picking up writebacks so it never issues stale operands.
            if (held_use1 && (bus.wb_rd == held_rs1)) op1_q <= bus.wb_data;
            if (held_use2 && (bus.wb_rd == held_rs2)) op2_q <= bus.wb_data;
`endif
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = out_valid_q;
    assign bus.op1       = op1_q;
    assign bus.op2       = op2_q;
    assign bus.opcode    = opcode_q;
    assign bus.funct3    = funct3_q;
    assign bus.funct7    = funct7_q;
    assign bus.rd        = rd_q;
endmodule

// File: tb/tb_ex_issue_stage.sv
// Bench for ex_issue_stage: directed test-plan scenarios plus randomized traffic against an instruction-level model.
module tb_ex_issue_stage;
  localparam int WIDTH   = 32;
  localparam int REGADDR = 5;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
`ifdef EX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ex_issue_stage_if #(.WIDTH(WIDTH), .REGADDR(REGADDR)) bus ();
  ex_issue_stage #(.WIDTH(WIDTH), .REGADDR(REGADDR)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;

  // Instruction held by the stage, as the model sees it.
  typedef struct {
    logic v;
    logic [WIDTH-1:0] op1, op2;
    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic [REGADDR-1:0] rd, rs1, rs2;
    logic u1, u2;
  } ent_t;
  ent_t m;
  bit m_zero = 1'b1;
  logic [REGADDR-1:0] exp_q[$];

  function automatic bit uses1(logic [6:0] o);
    return (o == OPC_OP) || (o == OPC_OPIMM) || (o == OPC_LOAD);
  endfunction

  function automatic bit uses2(logic [6:0] o);
    return o == OPC_OP;
  endfunction

  function automatic bit pending(logic wen, logic [REGADDR-1:0] wrd);
    bit r;
    r = 1'b0;
    if (wen && wrd != 0) begin
      if (uses1(bus.in_opcode) && wrd == bus.in_rs1) r = 1'b1;
      if (uses2(bus.in_opcode) && wrd == bus.in_rs2) r = 1'b1;
    end
    return r;
  endfunction

  function automatic bit m_hazard();
    if (FWD) return bus.exmem_is_load && pending(bus.exmem_wen, bus.exmem_rd);
    return pending(bus.exmem_wen, bus.exmem_rd) || pending(bus.wb_wen, bus.wb_rd);
  endfunction

  function automatic bit m_ready();
    return (!m.v || bus.out_ready) && !m_hazard() && !bus.flush;
  endfunction

  function automatic logic [WIDTH-1:0] src(logic [REGADDR-1:0] rs, logic [WIDTH-1:0] rf, bit used);
    if (rs == 0) return '0;
    if (FWD && used && bus.exmem_wen && !bus.exmem_is_load && bus.exmem_rd == rs) return bus.exmem_result;
    if (FWD && used && bus.wb_wen && bus.wb_rd == rs) return bus.wb_data;
    return rf;
  endfunction

  // Advance one clock: compute the model's next state from the inputs currently driven.
  task automatic tick();
    ent_t n;
    n = m;
    if (rst) begin
      n = '{default: '0};
      m_zero = 1'b1;
      exp_q.delete();
    end else if (bus.flush) begin
      n.v = 1'b0;
      m_zero = 1'b0;
      exp_q.delete();
    end else if (bus.in_valid && m_ready()) begin
      n.v   = 1'b1;
      n.opc = bus.in_opcode;
      n.f3  = bus.in_funct3;
      n.rd  = bus.in_rd;
      n.rs1 = bus.in_rs1;
      n.rs2 = bus.in_rs2;
      n.u1  = uses1(bus.in_opcode);
      n.u2  = uses2(bus.in_opcode);
      n.op1 = src(bus.in_rs1, bus.in_rs1_data, n.u1);
      n.op2 = (bus.in_opcode == OPC_OP) ? src(bus.in_rs2, bus.in_rs2_data, 1'b1) : bus.in_imm;
      if (bus.in_opcode == OPC_OP) n.f7 = bus.in_funct7;
      else if (bus.in_opcode == OPC_OPIMM && bus.in_funct3 == 3'b101) n.f7 = bus.in_imm[11:5];
      else n.f7 = 7'd0;
      m_zero = 1'b0;
      exp_q.push_back(bus.in_rd);
    end else if (m.v && bus.out_ready) begin
      n.v = 1'b0;
    end else if (m.v && FWD && bus.wb_wen && bus.wb_rd != 0) begin
      if (m.u1 && bus.wb_rd == m.rs1) n.op1 = bus.wb_data;
      if (m.u2 && bus.wb_rd == m.rs2) n.op2 = bus.wb_data;
    end
    @(posedge clk);
    m = n;
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid = 0; bus.in_opcode = 0; bus.in_funct3 = 0; bus.in_funct7 = 0;
    bus.in_rs1 = 0; bus.in_rs2 = 0; bus.in_rd = 0;
    bus.in_rs1_data = 0; bus.in_rs2_data = 0; bus.in_imm = 0;
    bus.exmem_wen = 0; bus.exmem_is_load = 0; bus.exmem_rd = 0; bus.exmem_result = 0;
    bus.wb_wen = 0; bus.wb_rd = 0; bus.wb_data = 0; bus.flush = 0; bus.out_ready = 1;
  endtask

  task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [REGADDR-1:0] rs1, input logic [REGADDR-1:0] rs2,
                       input logic [REGADDR-1:0] rd, input logic [WIDTH-1:0] d1,
                       input logic [WIDTH-1:0] d2, input logic [WIDTH-1:0] imm);
    bus.in_valid = 1; bus.in_opcode = opc; bus.in_funct3 = f3; bus.in_funct7 = f7;
    bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_rd = rd;
    bus.in_rs1_data = d1; bus.in_rs2_data = d2; bus.in_imm = imm;
  endtask

  task automatic drain();
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
    n_checks++; if (bus.op1 !== '0 || bus.op2 !== '0) begin n_errors++; $display("FAIL reset_ops: got %h/%h want 0/0", bus.op1, bus.op2); end
    n_checks++; if (bus.opcode !== 7'd0 || bus.funct3 !== 3'd0 || bus.funct7 !== 7'd0 || bus.rd !== '0) begin
      n_errors++; $display("FAIL reset_fields: got %h %h %h %h want 0", bus.opcode, bus.funct3, bus.funct7, bus.rd); end
    tick();
    n_checks++; if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_addi();
    idle_inputs();
    bus.out_ready = 0;
    drive(OPC_OPIMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd3, 32'd10, 32'd0, 32'd5);
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL addi_ready: got %b want 1", bus.in_ready); end
    tick();
    bus.in_valid = 0;
    n_checks++; if (bus.out_valid !== 1'b1) begin n_errors++; $display("FAIL addi_valid: got %b want 1", bus.out_valid); end
    n_checks++; if (bus.op1 !== 32'd10 || bus.op2 !== 32'd5) begin n_errors++; $display("FAIL addi_ops: got %h/%h want a/5", bus.op1, bus.op2); end
    n_checks++; if (bus.opcode !== OPC_OPIMM || bus.funct7 !== 7'd0 || bus.rd !== 5'd3) begin
      n_errors++; $display("FAIL addi_fields: got %b %b %0d want 0010011 0 3", bus.opcode, bus.funct7, bus.rd); end
    bus.out_ready = 1;
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL addi_drain: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_fwd_priority();
    idle_inputs();
    drive(OPC_OP, 3'd0, 7'd0, 5'd2, 5'd5, 5'd6, 32'h11, 32'h22, 32'h0);
    bus.exmem_wen = 1; bus.exmem_rd = 5'd2; bus.exmem_result = 32'h55;
    bus.wb_wen = 1; bus.wb_rd = 5'd2; bus.wb_data = 32'h99;
    #1;
    n_checks++; if (bus.in_ready !== m_ready()) begin n_errors++; $display("FAIL fwd_ready: got %b want %b", bus.in_ready, m_ready()); end
    tick();
    idle_inputs();
    bus.out_ready = 0;
    n_checks++; if (bus.out_valid !== m.v) begin n_errors++; $display("FAIL fwd_valid: got %b want %b", bus.out_valid, m.v); end
    n_checks++; if (bus.op1 !== m.op1) begin n_errors++; $display("FAIL fwd_op1: got %h want %h", bus.op1, m.op1); end
    n_checks++; if (bus.op2 !== m.op2) begin n_errors++; $display("FAIL fwd_op2: got %h want %h", bus.op2, m.op2); end
    drain();
  endtask

  task automatic test_load_use();
    bit got;
    got = 0;
    idle_inputs();
    drive(OPC_OP, 3'd0, 7'b0100000, 5'd1, 5'd4, 5'd8, 32'h100, 32'h200, 32'h0);
    for (int c = 0; c < 8 && !got; c++) begin
      bus.exmem_wen = (c < 2); bus.exmem_is_load = (c < 2); bus.exmem_rd = 5'd4; bus.exmem_result = 32'hBAD;
      bus.wb_wen = (c == 2 || c == 3); bus.wb_rd = 5'd4; bus.wb_data = 32'h77;
      #1;
      n_checks++; if (bus.in_ready !== m_ready()) begin n_errors++; $display("FAIL lu_ready_c%0d: got %b want %b", c, bus.in_ready, m_ready()); end
      got = bus.in_valid && m_ready();
      tick();
    end
    idle_inputs();
    bus.out_ready = 0;
    n_checks++; if (!got) begin n_errors++; $display("FAIL lu_timeout: got no capture want capture"); end
    n_checks++; if (bus.out_valid !== 1'b1) begin n_errors++; $display("FAIL lu_valid: got %b want 1", bus.out_valid); end
    n_checks++; if (bus.op2 !== m.op2) begin n_errors++; $display("FAIL lu_op2: got %h want %h", bus.op2, m.op2); end
    n_checks++; if (bus.funct7 !== 7'b0100000) begin n_errors++; $display("FAIL lu_funct7: got %b want 0100000", bus.funct7); end
    drain();
  endtask

  task automatic test_snoop();
    idle_inputs();
    bus.out_ready = 0;
    drive(OPC_OPIMM, 3'd0, 7'd0, 5'd7, 5'd0, 5'd9, 32'h1234, 32'h0, 32'h1);
    tick();
    bus.in_valid = 0;
    bus.wb_wen = 1; bus.wb_rd = 5'd7; bus.wb_data = 32'hDEAD;
    #1;
    n_checks++; if (bus.in_ready !== 1'b0) begin n_errors++; $display("FAIL snoop_ready: got %b want 0", bus.in_ready); end
    tick();
    n_checks++; if (bus.out_valid !== 1'b1) begin n_errors++; $display("FAIL snoop_valid: got %b want 1", bus.out_valid); end
    n_checks++; if (bus.op1 !== m.op1) begin n_errors++; $display("FAIL snoop_op1: got %h want %h", bus.op1, m.op1); end
    bus.wb_rd = 5'd0; bus.wb_data = 32'hBEEF;
    tick();
    n_checks++; if (bus.op1 !== m.op1) begin n_errors++; $display("FAIL snoop_x0: got %h want %h", bus.op1, m.op1); end
    drain();
  endtask

  task automatic test_srai();
    idle_inputs();
    drive(OPC_OPIMM, 3'b101, 7'b1111111, 5'd0, 5'd0, 5'd5, 32'hFFFF, 32'h0, 32'h403);
    tick();
    idle_inputs();
    bus.out_ready = 0;
    n_checks++; if (bus.funct7 !== 7'b0100000) begin n_errors++; $display("FAIL srai_funct7: got %b want 0100000", bus.funct7); end
    n_checks++; if (bus.op2 !== 32'h403) begin n_errors++; $display("FAIL srai_op2: got %h want 403", bus.op2); end
    n_checks++; if (bus.op1 !== 32'h0) begin n_errors++; $display("FAIL srai_x0: got %h want 0", bus.op1); end
    n_checks++; if (bus.funct3 !== 3'b101) begin n_errors++; $display("FAIL srai_funct3: got %b want 101", bus.funct3); end
    drain();
  endtask

  task automatic test_flush();
    idle_inputs();
    bus.out_ready = 0;
    drive(OPC_OPIMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd3, 32'd10, 32'd0, 32'd5);
    tick();
    bus.flush = 1;
    drive(OPC_OP, 3'd0, 7'd0, 5'd2, 5'd3, 5'd4, 32'h1, 32'h2, 32'h0);
    #1;
    n_checks++; if (bus.in_ready !== 1'b0) begin n_errors++; $display("FAIL flush_ready: got %b want 0", bus.in_ready); end
    tick();
    bus.flush = 0; bus.in_valid = 0;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL flush_valid: got %b want 0", bus.out_valid); end
    bus.out_ready = 1;
    drive(OPC_OPIMM, 3'd0, 7'd0, 5'd2, 5'd0, 5'd6, 32'h42, 32'h0, 32'h7);
    tick();
    n_checks++; if (bus.out_valid !== 1'b1 || bus.op1 !== 32'h42) begin n_errors++; $display("FAIL flush_recap: got %b/%h want 1/42", bus.out_valid, bus.op1); end
    rst = 1;
    tick();
    rst = 0;
    bus.in_valid = 0;
    n_checks++; if (bus.out_valid !== 1'b0 || bus.op1 !== '0 || bus.op2 !== '0) begin
      n_errors++; $display("FAIL midrst_ops: got %b/%h/%h want 0/0/0", bus.out_valid, bus.op1, bus.op2); end
    n_checks++; if (bus.opcode !== 7'd0 || bus.funct3 !== 3'd0 || bus.funct7 !== 7'd0 || bus.rd !== '0) begin
      n_errors++; $display("FAIL midrst_fields: got %h %h %h %h want 0", bus.opcode, bus.funct3, bus.funct7, bus.rd); end
    drain();
  endtask

  task automatic test_random();
    logic [6:0] opcs [5];
    opcs[0] = OPC_OP; opcs[1] = OPC_OPIMM; opcs[2] = OPC_LOAD; opcs[3] = OPC_STORE; opcs[4] = OPC_LUI;
    exp_q.delete();
    for (int i = 0; i < 600; i++) begin
      drive(opcs[$urandom_range(0, 4)], 3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), $urandom, $urandom, $urandom);
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.exmem_wen = $urandom_range(0, 1); bus.exmem_is_load = ($urandom_range(0, 2) == 0);
      bus.exmem_rd = 5'($urandom_range(0, 3)); bus.exmem_result = $urandom;
      bus.wb_wen = $urandom_range(0, 1); bus.wb_rd = 5'($urandom_range(0, 3)); bus.wb_data = $urandom;
      bus.out_ready = ($urandom_range(0, 9) < 6);
      bus.flush = ($urandom_range(0, 19) == 0);
      rst = ($urandom_range(0, 99) == 0);
      #1;
      n_checks++; if (bus.in_ready !== m_ready()) begin n_errors++; $display("FAIL rand_ready[%0d]: got %b want %b", i, bus.in_ready, m_ready()); end
      if (m.v && bus.out_ready && !bus.flush && !rst) begin
        n_checks++;
        if (exp_q.size() == 0) begin n_errors++; $display("FAIL rand_consume[%0d]: got rd %0d want none", i, bus.rd); end
        else begin
          logic [REGADDR-1:0] e;
          e = exp_q.pop_front();
          if (bus.rd !== e) begin n_errors++; $display("FAIL rand_consume[%0d]: got rd %0d want %0d", i, bus.rd, e); end
        end
      end
      tick();
      n_checks++; if (bus.out_valid !== m.v) begin n_errors++; $display("FAIL rand_valid[%0d]: got %b want %b", i, bus.out_valid, m.v); end
      if (m.v || m_zero) begin
        n_checks++; if (bus.op1 !== m.op1) begin n_errors++; $display("FAIL rand_op1[%0d]: got %h want %h", i, bus.op1, m.op1); end
        n_checks++; if (bus.op2 !== m.op2) begin n_errors++; $display("FAIL rand_op2[%0d]: got %h want %h", i, bus.op2, m.op2); end
        n_checks++; if (bus.opcode !== m.opc || bus.funct3 !== m.f3 || bus.funct7 !== m.f7 || bus.rd !== m.rd) begin
          n_errors++; $display("FAIL rand_fields[%0d]: got %b %b %b %0d want %b %b %b %0d", i,
                               bus.opcode, bus.funct3, bus.funct7, bus.rd, m.opc, m.f3, m.f7, m.rd); end
      end
    end
    rst = 0;
    drain();
  endtask

  initial begin
    m = '{default: '0};
    test_reset();
    test_addi();
    test_fwd_priority();
    test_load_use();
    test_snoop();
    test_srai();
    test_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
